// File: rtl/z80_bus_capture_pkg.sv
// Shared types and record layout for the Z80 bus-cycle tracer.
// Z80_BUS_CAPTURE_TIMESTAMP_EN widens each record with a 16-bit start timestamp.
package z80_bus_capture_pkg;

  typedef enum logic [1:0] {
    CYC_FETCH = 2'b00,
    CYC_MRD   = 2'b01,
    CYC_MWR   = 2'b10,
    CYC_IO    = 2'b11
  } cyc_type_e;

  localparam int DATA_LSB = 0;
  localparam int ADDR_LSB = 8;
  localparam int TYPE_LSB = 24;
  localparam int TS_LSB   = 26;
  localparam int TS_W     = 16;
`ifdef Z80_BUS_CAPTURE_TIMESTAMP_EN
  localparam int REC_W    = 42;
`else
  localparam int REC_W    = 26;
`endif

  // Caller guarantees the cycle is active, so iorq_n=1 implies mreq_n=0.
  function automatic cyc_type_e classify(input logic iorq_n, input logic m1_n,
                                         input logic rd_n);
    if (!iorq_n)         return CYC_IO;
    if (!m1_n && !rd_n)  return CYC_FETCH;
    if (!rd_n)           return CYC_MRD;
    return CYC_MWR;
  endfunction

endpackage

// File: rtl/z80_bus_capture_fifo.sv
// First-word-fall-through FIFO; a push while full is accepted only alongside a pop.
module z80_bus_capture_fifo #(
  parameter int WIDTH = 26,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push, do_pop;

  assign empty   = (level_q == '0);
  assign full    = (level_q == LW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign level   = level_q;
  // Gate the head so the output reads zero rather than stale storage when empty.
  assign rdata   = empty ? '0 : mem[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    level_d  = level_q + LW'(do_push) - LW'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/z80_bus_capture.sv
// Z80 bus-cycle tracer: classifies each completed bus cycle and queues one record per cycle.
// Define Z80_BUS_CAPTURE_TIMESTAMP_EN to prepend the cycle-start timestamp to each record.
module z80_bus_capture
  import z80_bus_capture_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter bit CAP_IO = 1'b1
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  input  logic                   en,
  input  logic                   mreq_n,
  input  logic                   iorq_n,
  input  logic                   rd_n,
  input  logic                   wr_n,
  input  logic                   m1_n,
  input  logic                   rfsh_n,
  input  logic [15:0]            addr,
  input  logic [7:0]             dout,
  input  logic [7:0]             din,
  output logic                   rec_valid,
  input  logic                   rec_ready,
  output logic [REC_W-1:0]       rec_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  input  logic                   clr_ovf
);
  logic          active, keep, push, full, empty;
  logic          idle_q, idle_d, in_cyc_q, in_cyc_d, keep_q, keep_d;
  logic          overflow_q, overflow_d;
  cyc_type_e     type_q, type_d;
  logic [15:0]   addr_q, addr_d;
  logic [7:0]    data_q, data_d;
  logic [REC_W-1:0] rec_in;

  assign active = (~mreq_n | ~iorq_n) & (~rd_n | ~wr_n) & rfsh_n;
  assign keep   = ~(~m1_n & ~iorq_n) & (iorq_n | CAP_IO);
  // idle_q resets low so a cycle already in progress at reset release is never started.
  assign push   = in_cyc_q & ~active & keep_q & en;

  always_comb begin
    idle_d   = ~active;
    in_cyc_d = active & (in_cyc_q | idle_q);
    type_d   = type_q;
    addr_d   = addr_q;
    data_d   = data_q;
    keep_d   = keep_q;
    if (active) begin
      type_d = classify(iorq_n, m1_n, rd_n);
      addr_d = addr;
      data_d = rd_n ? dout : din;
      keep_d = keep;
    end
    overflow_d = (push & full & ~rec_ready) | (overflow_q & ~clr_ovf);
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      idle_q     <= 1'b0;
      in_cyc_q   <= 1'b0;
      keep_q     <= 1'b0;
      type_q     <= CYC_FETCH;
      addr_q     <= '0;
      data_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      idle_q     <= idle_d;
      in_cyc_q   <= in_cyc_d;
      keep_q     <= keep_d;
      type_q     <= type_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef Z80_BUS_CAPTURE_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q, ts_d, ts_start_q, ts_start_d;

  always_comb begin
    ts_d       = ts_q + 16'd1;
    ts_start_d = (active & idle_q) ? ts_q : ts_start_q;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ts_q       <= '0;
      ts_start_q <= '0;
    end else begin
      ts_q       <= ts_d;
      ts_start_q <= ts_start_d;
    end
  end

  assign rec_in = {ts_start_q, type_q, addr_q, data_q};
`else
  assign rec_in = {type_q, addr_q, data_q};
`endif

  z80_bus_capture_fifo #(.WIDTH(REC_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .push  (push),
    .pop   (rec_ready),
    .wdata (rec_in),
    .rdata (rec_data),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign rec_valid = ~empty;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_z80_bus_capture.sv
// Scoreboard bench: two tracers (16-deep with IO, 4-deep without IO) snoop one emulated Z80 bus.
module tb_z80_bus_capture;
  import z80_bus_capture_pkg::*;

  localparam int DA = 16, DB = 4;
  localparam int K_FETCH = 0, K_MRD = 1, K_MWR = 2, K_IOW = 3, K_INTA = 4, K_IOR = 5;
  typedef logic [REC_W-1:0] rec_t;

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic en, mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n, clr_ovf, rdy_a, rdy_b;
  logic [15:0] addr;
  logic [7:0]  dout, din;
  logic        val_a, val_b, ovf_a, ovf_b;
  rec_t        data_a, data_b;
  logic [4:0]  level_a;
  logic [2:0]  level_b;

  z80_bus_capture #(.DEPTH(DA), .CAP_IO(1'b1)) dut_a (
    .wb_clk_i(clk), .wb_rst_i(rst), .en(en), .mreq_n(mreq_n), .iorq_n(iorq_n),
    .rd_n(rd_n), .wr_n(wr_n), .m1_n(m1_n), .rfsh_n(rfsh_n), .addr(addr), .dout(dout),
    .din(din), .rec_valid(val_a), .rec_ready(rdy_a), .rec_data(data_a), .level(level_a),
    .overflow(ovf_a), .clr_ovf(clr_ovf));

  z80_bus_capture #(.DEPTH(DB), .CAP_IO(1'b0)) dut_b (
    .wb_clk_i(clk), .wb_rst_i(rst), .en(en), .mreq_n(mreq_n), .iorq_n(iorq_n),
    .rd_n(rd_n), .wr_n(wr_n), .m1_n(m1_n), .rfsh_n(rfsh_n), .addr(addr), .dout(dout),
    .din(din), .rec_valid(val_b), .rec_ready(rdy_b), .rec_data(data_b), .level(level_b),
    .overflow(ovf_b), .clr_ovf(clr_ovf));

  rec_t qa[$], qb[$];
  bit   eovf_a, eovf_b, rnd_rdy;
  int   tests = 0, fails = 0;
  logic [15:0] tcnt;
  logic [6:0]  rfsh_addr = '0;

  // Clocks elapsed since reset release; the start timestamp of a cycle.
  always @(posedge clk or posedge rst)
    if (rst) tcnt <= '0; else tcnt <= tcnt + 16'd1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: occupancy/flags every cycle, record contents on every accepted pop.
  always @(negedge clk) if (!rst) begin
    chk("level_a", 64'(level_a), 64'(qa.size()));
    chk("ovf_a",   64'(ovf_a),   64'(eovf_a));
    chk("valid_a", 64'(val_a),   64'(qa.size() != 0));
    chk("level_b", 64'(level_b), 64'(qb.size()));
    chk("ovf_b",   64'(ovf_b),   64'(eovf_b));
    chk("valid_b", 64'(val_b),   64'(qb.size() != 0));
    if (val_a && rdy_a) begin
      tests++;
      if (qa.size() == 0) begin fails++; $display("FAIL rec_a: got %0h want none", data_a); end
      else begin
        if (data_a !== qa[0]) begin fails++; $display("FAIL rec_a: got %0h want %0h", data_a, qa[0]); end
        void'(qa.pop_front());
      end
    end
    if (val_b && rdy_b) begin
      tests++;
      if (qb.size() == 0) begin fails++; $display("FAIL rec_b: got %0h want none", data_b); end
      else begin
        if (data_b !== qb[0]) begin fails++; $display("FAIL rec_b: got %0h want %0h", data_b, qb[0]); end
        void'(qb.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
    if (rnd_rdy) begin
      rdy_a = ($urandom_range(0, 3) != 0);
      rdy_b = ($urandom_range(0, 1) != 0);
    end
  endtask

  task automatic idle();
    mreq_n = 1; iorq_n = 1; rd_n = 1; wr_n = 1; m1_n = 1; rfsh_n = 1;
  endtask

  // One Z80 bus cycle; fetches are followed by a refresh slot as on real silicon.
  task automatic bus(input int kind, input logic [15:0] a, input logic [7:0] d,
                     input int waits, input bit clr = 0, input bit pop_b_end = 0);
    rec_t r;
    logic [1:0] t;
    bit drop;
`ifdef Z80_BUS_CAPTURE_TIMESTAMP_EN
    logic [15:0] ts;
    ts = tcnt;
`endif
    t = (kind == K_FETCH) ? 2'b00 : (kind == K_MRD) ? 2'b01 : (kind == K_MWR) ? 2'b10 : 2'b11;
`ifdef Z80_BUS_CAPTURE_TIMESTAMP_EN
    r = {ts, t, a, d};
`else
    r = {t, a, d};
`endif
    addr = a; din = 8'($urandom); dout = 8'($urandom);
    case (kind)
      K_FETCH: begin m1_n = 0; mreq_n = 0; rd_n = 0; din = d; end
      K_MRD:   begin mreq_n = 0; rd_n = 0; din = d; end
      K_MWR:   begin mreq_n = 0; wr_n = 0; dout = d; end
      K_IOW:   begin iorq_n = 0; wr_n = 0; dout = d; end
      K_IOR:   begin iorq_n = 0; rd_n = 0; din = d; end
      default: begin m1_n = 0; iorq_n = 0; end
    endcase
    repeat (1 + waits) step();
    idle();
    clr_ovf = clr;
    if (pop_b_end) rdy_b = 1;
    @(posedge clk);
    if (kind != K_INTA && en) begin
      drop = 0;
      if (qa.size() < DA) qa.push_back(r); else drop = 1;
      eovf_a = drop ? 1'b1 : (clr ? 1'b0 : eovf_a);
      drop = 0;
      if (kind != K_IOW && kind != K_IOR) begin
        if (qb.size() < DB) qb.push_back(r); else drop = 1;
      end
      eovf_b = drop ? 1'b1 : (clr ? 1'b0 : eovf_b);
    end else if (clr) begin
      eovf_a = 0; eovf_b = 0;
    end
    #1;
    clr_ovf = 0;
    if (pop_b_end) rdy_b = 0;
    if (kind == K_FETCH) begin
      addr = {9'h0, rfsh_addr}; rfsh_addr++;
      mreq_n = 0; rfsh_n = 0;
      step();
      idle();
      step();
    end
  endtask

  task automatic clear_ovf();
    clr_ovf = 1;
    @(posedge clk);
    eovf_a = 0; eovf_b = 0;
    #1 clr_ovf = 0;
  endtask

  task automatic drain();
    int n = 0;
    rdy_a = 1; rdy_b = 1;
    while ((qa.size() != 0 || qb.size() != 0) && n < 200) begin step(); n++; end
    step();
    chk("drain_timeout", 64'(qa.size() + qb.size()), 64'd0);
    rdy_a = 0; rdy_b = 0;
  endtask

  initial begin
    idle();
    en = 1; clr_ovf = 0; rdy_a = 0; rdy_b = 0; rnd_rdy = 0;
    addr = 0; dout = 0; din = 0;
    eovf_a = 0; eovf_b = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    step();
    chk("reset_level_a", 64'(level_a), 64'd0);
    chk("reset_data_a",  64'(data_a),  64'd0);

    // LD A,3Eh / SUB 21h / LD (AA20h),A
    bus(K_FETCH, 16'h0000, 8'h3E, 0);
    bus(K_MRD,   16'h0001, 8'h3E, 0);
    bus(K_FETCH, 16'h0002, 8'hD6, 0);
    bus(K_MRD,   16'h0003, 8'h21, 0);
    bus(K_FETCH, 16'h0004, 8'h32, 0);
    bus(K_MRD,   16'h0005, 8'h20, 0);
    bus(K_MRD,   16'h0006, 8'hAA, 0);
    bus(K_MWR,   16'hAA20, 8'h1D, 0);
    chk("prog_level", 64'(level_a), 64'd8);
    chk("prog_ovf",   64'(ovf_a),   64'd0);
    chk("prog_head",  64'(data_a[25:0]), 64'(26'h000_003E));
    drain();
    clear_ovf();

    // Wait states and refresh: exactly one record.
    bus(K_FETCH, 16'h0000, 8'h3E, 3);
    chk("wait_one_rec", 64'(level_a), 64'd1);
    drain();

    // Capture disabled at cycle end: dropped, no overflow.
    en = 0;
    bus(K_MRD, 16'h1234, 8'h99, 1);
    chk("en_off_level", 64'(level_a), 64'd0);
    en = 1;

    // OUT (12h),A with A=55h, then an interrupt acknowledge.
    bus(K_IOW,  16'h5512, 8'h55, 1);
    bus(K_INTA, 16'h0038, 8'hFF, 2);
    chk("io_level_a", 64'(level_a), 64'd1);
    chk("io_level_b", 64'(level_b), 64'd0);
    chk("io_rec_a",   64'(data_a[25:0]), 64'({2'b11, 16'h5512, 8'h55}));
    drain();

    // Overflow on the 4-deep tracer.
    for (int i = 0; i < 6; i++) bus(K_MRD, 16'h2000 + 16'(i), 8'(8'h40 + i), 0);
    chk("ovf_level_b", 64'(level_b), 64'd4);
    chk("ovf_flag_b",  64'(ovf_b),   64'd1);
    clear_ovf();
    chk("ovf_cleared", 64'(ovf_b), 64'd0);

    // Full with simultaneous pop: accepted at the tail, no overflow.
    bus(K_MRD, 16'h3000, 8'h77, 0, 0, 1);
    chk("fullpop_level", 64'(level_b), 64'd4);
    chk("fullpop_ovf",   64'(ovf_b),   64'd0);
    chk("fullpop_tail",  64'(qb[3][25:0]), 64'({2'b01, 16'h3000, 8'h77}));

    // Clear and overflow in the same clock: set wins.
    bus(K_MRD, 16'h3001, 8'h78, 0, 1);
    chk("setwins_ovf", 64'(ovf_b), 64'd1);
    drain();
    clear_ovf();

    // Asynchronous reset in the middle of a fetch.
    addr = 16'h0100; din = 8'hC3; m1_n = 0; mreq_n = 0; rd_n = 0;
    step();
    #2 rst = 1;
    #1;
    chk("rst_valid_a", 64'(val_a),   64'd0);
    chk("rst_level_a", 64'(level_a), 64'd0);
    chk("rst_data_b",  64'(data_b),  64'd0);
    chk("rst_ovf_b",   64'(ovf_b),   64'd0);
    qa.delete(); qb.delete(); eovf_a = 0; eovf_b = 0;
    step(); step();
    rst = 0;
    step(); step();
    idle();
    step(); step();
    chk("rst_partial_dropped", 64'(level_a), 64'd0);
    bus(K_MRD, 16'h0101, 8'h5A, 1);
    chk("rst_first_level", 64'(level_a), 64'd1);
    drain();

    // Randomized traffic with random back-pressure.
    rnd_rdy = 1;
    for (int i = 0; i < 400; i++) begin
      en = ($urandom_range(0, 9) != 0);
      bus(int'($urandom_range(0, 5)), 16'($urandom), 8'($urandom),
          int'($urandom_range(0, 2)), ($urandom_range(0, 15) == 0));
    end
    rnd_rdy = 0; en = 1;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
